// File: rtl/mem_responder.sv
// Single-port word memory answering fetch, read and write requests after WAIT_CYC wait states.
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses set a sticky err_align, suppress writes and return 0.
module mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int WAIT_CYC   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] pc_addr,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] ir_out,
  output logic        W_IR_valid,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        wr_ack,
  output logic        busy,
  output logic        err_align
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {OP_FETCH, OP_READ, OP_WRITE} op_t;

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] ir_out_q, ir_out_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ir_vld_q, ir_vld_d;
  logic        rd_vld_q, rd_vld_d;
  logic        ack_q, ack_d;

  logic                  any_req;
  logic [31:0]           req_addr;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  misalign;
  logic                  mem_we;
  logic                  mem_re;
  logic [31:0]           resp_word;
  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           mem_rd_q;
  logic                  unused_addr_bits;

  assign any_req  = wr_req | rd_req | fetch_req;
  assign req_addr = (wr_req | rd_req) ? addr : pc_addr;
  assign word_idx = addr_q[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^addr_q;

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q, err_d;
  assign misalign  = (addr_q[1:0] != 2'b00);
  assign err_align = err_q;
`else
  assign misalign  = 1'b0;
  assign err_align = 1'b0;
`endif

  assign mem_we    = (state_q == ACCESS) && (op_q == OP_WRITE) && !misalign;
  assign mem_re    = (state_q == ACCESS) && (op_q != OP_WRITE);
  assign resp_word = misalign ? 32'h0 : mem_rd_q;

  // Memory is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[word_idx] <= wdata_q;
    end
    if (mem_re) begin
      mem_rd_q <= mem_q[word_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = (WAIT_CYC > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latching and response generation; pulses are registered so they
  // appear the cycle after RESP, WAIT_CYC+2 edges after acceptance.
  always_comb begin
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    ir_out_d = ir_out_q;
    rdata_d  = rdata_q;
    ir_vld_d = 1'b0;
    rd_vld_d = 1'b0;
    ack_d    = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          if (wr_req) begin
            op_d = OP_WRITE;
          end else if (rd_req) begin
            op_d = OP_READ;
          end else begin
            op_d = OP_FETCH;
          end
          addr_d  = req_addr;
          wdata_d = wdata;
          cnt_d   = WAIT_INIT;
`ifdef MEM_ALIGN_CHECK_EN
          if (req_addr[1:0] != 2'b00) begin
            err_d = 1'b1;
          end
`endif
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: begin
        unique case (op_q)
          OP_FETCH: begin
            ir_out_d = resp_word;
            ir_vld_d = 1'b1;
          end
          OP_READ: begin
            rdata_d  = resp_word;
            rd_vld_d = 1'b1;
          end
          OP_WRITE: ack_d = 1'b1;
          default:  ack_d = 1'b0;
        endcase
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= OP_FETCH;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      cnt_q    <= 4'd0;
      ir_out_q <= 32'h0;
      rdata_q  <= 32'h0;
      ir_vld_q <= 1'b0;
      rd_vld_q <= 1'b0;
      ack_q    <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      ir_out_q <= ir_out_d;
      rdata_q  <= rdata_d;
      ir_vld_q <= ir_vld_d;
      rd_vld_q <= rd_vld_d;
      ack_q    <= ack_d;
`ifdef MEM_ALIGN_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign ir_out      = ir_out_q;
  assign W_IR_valid  = ir_vld_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rd_vld_q;
  assign wr_ack      = ack_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the number of 32-bit words in internal memory.
REQ-002 The block SHALL have parameter WAIT_CYC, default 2, meaning the number of wait cycles before an access completes (legal range 0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: clock, all state on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port fetch_req, input, 1 bit: instruction fetch request, driven from the controller's write_ir.
REQ-006 The block SHALL have port pc_addr, input, 32 bits: fetch byte address.
REQ-007 The block SHALL have port rd_req, input, 1 bit: data read request.
REQ-008 The block SHALL have port wr_req, input, 1 bit: data write request, driven from the controller's mem_write.
REQ-009 The block SHALL have port addr, input, 32 bits: data byte address.
REQ-010 The block SHALL have port wdata, input, 32 bits: write data.
REQ-011 The block SHALL have port ir_out, output, 32 bits: fetched instruction word.
REQ-012 The block SHALL have port W_IR_valid, output, 1 bit: one-cycle pulse marking ir_out valid.
REQ-013 The block SHALL have port rdata, output, 32 bits: read data.
REQ-014 The block SHALL have port rdata_valid, output, 1 bit: one-cycle pulse marking rdata valid.
REQ-015 The block SHALL have port wr_ack, output, 1 bit: one-cycle pulse marking write committed.
REQ-016 The block SHALL have port busy, output, 1 bit: high while any access is in progress.
REQ-017 The block SHALL have port err_align, output, 1 bit: sticky misalignment flag, present only under MEM_ALIGN_CHECK_EN.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT, ACCESS, and RESP, and SHALL hold an op register (FETCH/READ/WRITE), a latched address, latched wdata, and a 4-bit wait counter.
REQ-019 In IDLE, requests SHALL be sampled at each rising edge with priority wr_req > rd_req > fetch_req; lower-priority simultaneous requests SHALL be dropped, not queued.
REQ-020 On acceptance, the op, address, and wdata SHALL be latched, the counter loaded with WAIT_CYC, and the next state SHALL be WAIT if WAIT_CYC>0, else ACCESS.
REQ-021 In WAIT, the counter SHALL decrement each cycle, with the transition to ACCESS when the counter equals 1.
REQ-022 In ACCESS, FETCH/READ SHALL load the word into ir_out/rdata and WRITE SHALL commit mem[word] <= wdata; the next state SHALL be RESP.
REQ-023 In RESP, exactly one of W_IR_valid/rdata_valid/wr_ack SHALL be high for one cycle, and the next state SHALL be IDLE.
REQ-024 The response pulse SHALL occur WAIT_CYC+2 cycles after the accepting edge.
REQ-025 busy SHALL be high in WAIT, ACCESS, and RESP, and low in IDLE.
REQ-026 Requests arriving while busy SHALL be ignored.
REQ-027 The word index SHALL be address[DEPTH_LOG2+1:2]; upper bits SHALL be ignored, so addresses alias modulo 4*2^DEPTH_LOG2.
REQ-028 ir_out and rdata SHALL hold their last value between responses.
REQ-029 A level-held fetch_req SHALL re-issue a new fetch on the IDLE edge following RESP.

Reset
REQ-030 When rst is asserted, the block SHALL immediately force state to IDLE, counter to 0, and ir_out, rdata, W_IR_valid, rdata_valid, wr_ack, busy, and err_align to 0.
REQ-031 Memory contents SHALL NOT be cleared by reset.
REQ-032 When reset is asserted mid-access, the pending access SHALL be abandoned: no write committed if before ACCESS, and no response pulse issued.
REQ-033 The first request SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-034 The macro MEM_ALIGN_CHECK_EN SHALL control alignment checking.
REQ-035 When MEM_ALIGN_CHECK_EN is defined, an accepted access with address[1:0]!=0 SHALL set err_align (sticky until reset), suppress the write, and return 0 for reads and fetches; the response pulse SHALL still be issued with the same timing.
REQ-036 When MEM_ALIGN_CHECK_EN is undefined, address[1:0] SHALL be ignored, err_align SHALL be tied 0, and the access SHALL proceed to the containing word.

Verification
REQ-037 The bench SHALL preload mem[2]=0xE3A01005, raise fetch_req with pc_addr=0x8 accepted at edge N, and require W_IR_valid high only in the cycle after edge N+4 with ir_out=0xE3A01005.
REQ-038 The bench SHALL write 0xDEADBEEF to addr=0x10, then read addr=0x10, and require wr_ack for one cycle followed by rdata_valid with rdata=0xDEADBEEF.
REQ-039 The bench SHALL raise wr_req, rd_req, and fetch_req on the same edge, and require only wr_ack to pulse, busy high for 4 cycles, and no W_IR_valid or rdata_valid.
REQ-040 The bench SHALL assert rst during WAIT of a write to 0x20 (mem[8]=0x0), and require no wr_ack, busy=0 immediately, and mem[8] still 0x0.
REQ-041 The bench SHALL write 0x12345678 to addr=0x400 with DEPTH_LOG2=8, and require that a read of addr=0x0 returns 0x12345678.
REQ-042 The bench SHALL write 0xCAFEF00D to addr=0x13, and require with MEM_ALIGN_CHECK_EN: wr_ack pulses, err_align=1, mem[4] unchanged; and without it: mem[4]=0xCAFEF00D, err_align=0.
